// File: rtl/draw_square.sv
// rtl/draw_square.sv - rasterises one (x, y, colour) request into a SIZE x SIZE pixel burst.
// Optional screen-edge clipping is enabled by defining DRAW_SQUARE_CLIP_EN.
module draw_square #(
  parameter int SIZE     = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clock,
  input  logic       clear_b,
  input  logic       start,
  input  logic [7:0] square_x,
  input  logic [6:0] square_y,
  input  logic [2:0] colour_in,
  output logic       ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(SIZE - 1);

`ifdef DRAW_SQUARE_CLIP_EN
  localparam int XW = 9;
  localparam int YW = 8;
`else
  localparam int XW = 8;
  localparam int YW = 7;
`endif

  state_t     state_q, state_d;
  logic [7:0] sx_q, sx_d;
  logic [6:0] sy_q, sy_d;
  logic [2:0] col_q, col_d;
  logic [3:0] dx_q, dx_d;
  logic [3:0] dy_q, dy_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_col_q, vga_col_d;
  logic       plot_q, plot_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;

  // Pixel selected for the next output cycle, and its screen coordinates
  logic          load_pix;
  logic [7:0]    pix_sx;
  logic [6:0]    pix_sy;
  logic [3:0]    pix_dx;
  logic [3:0]    pix_dy;
  logic [2:0]    pix_col;
  logic [XW-1:0] sum_x;
  logic [YW-1:0] sum_y;

  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      state_q   <= S_IDLE;
      sx_q      <= '0;
      sy_q      <= '0;
      col_q     <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      vga_col_q <= '0;
      plot_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      col_q     <= col_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      vga_x_q   <= vga_x_d;
      vga_y_q   <= vga_y_d;
      vga_col_q <= vga_col_d;
      plot_q    <= plot_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    col_d     = col_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    vga_x_d   = vga_x_q;
    vga_y_d   = vga_y_q;
    vga_col_d = vga_col_q;
    plot_d    = 1'b0;
    done_d    = 1'b0;
    ready_d   = 1'b1;
    load_pix  = 1'b0;
    pix_sx    = sx_q;
    pix_sy    = sy_q;
    pix_dx    = dx_q;
    pix_dy    = dy_q;
    pix_col   = col_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a request exactly like IDLE so squares can run back to back
        if (start) begin
          sx_d     = square_x;
          sy_d     = square_y;
          col_d    = colour_in;
          dx_d     = '0;
          dy_d     = '0;
          state_d  = S_DRAW;
          ready_d  = 1'b0;
          load_pix = 1'b1;
          pix_sx   = square_x;
          pix_sy   = square_y;
          pix_dx   = '0;
          pix_dy   = '0;
          pix_col  = colour_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAW: begin
        if (dx_q == LAST && dy_q == LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          ready_d  = 1'b0;
          load_pix = 1'b1;
          if (dx_q == LAST) begin
            dx_d = '0;
            dy_d = dy_q + 4'd1;
          end else begin
            dx_d = dx_q + 4'd1;
          end
          pix_dx = dx_d;
          pix_dy = dy_d;
        end
      end
      default: state_d = S_IDLE;
    endcase

    sum_x = XW'(pix_sx) + XW'(pix_dx);
    sum_y = YW'(pix_sy) + YW'(pix_dy);

    if (load_pix) begin
      vga_x_d   = sum_x[7:0];
      vga_y_d   = sum_y[6:0];
      vga_col_d = pix_col;
`ifdef DRAW_SQUARE_CLIP_EN
      plot_d    = (int'(sum_x) < SCREEN_W) && (int'(sum_y) < SCREEN_H);
`else
      plot_d    = 1'b1;
`endif
    end
  end

  assign ready      = ready_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_col_q;
  assign plot       = plot_q;
  assign done       = done_q;

endmodule

// File: tb/tb_draw_square.sv
// tb/tb_draw_square.sv - directed self-checking bench for draw_square (default SIZE=4).
module tb_draw_square;

  logic       clock = 1'b0;
  logic       clear_b;
  logic       start;
  logic [7:0] square_x;
  logic [6:0] square_y;
  logic [2:0] colour_in;
  logic       ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       done;

  int checks   = 0;
  int failures = 0;

  draw_square dut (
    .clock      (clock),
    .clear_b    (clear_b),
    .start      (start),
    .square_x   (square_x),
    .square_y   (square_y),
    .colour_in  (colour_in),
    .ready      (ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    clear_b   = 1'b0;
    start     = 1'b1;
    square_x  = 8'd55;
    square_y  = 7'd44;
    colour_in = 3'b111;
    repeat (3) tick;
    checks++;
    if ({ready, plot, done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl got ready/plot/done=%b want 100", {ready, plot, done});
    end
    checks++;
    if ({vga_x, vga_y, vga_colour} !== 18'd0) begin
      failures++;
      $display("FAIL reset_vga got x=%0d y=%0d c=%0d want 0 0 0", vga_x, vga_y, vga_colour);
    end
    start   = 1'b0;
    clear_b = 1'b1;
    repeat (2) begin
      tick;
      checks++;
      if (plot !== 1'b0 || ready !== 1'b1) begin
        failures++;
        $display("FAIL post_reset_idle got plot=%b ready=%b want 0 1", plot, ready);
      end
    end
  endtask

  task automatic test_single;
    square_x  = 8'd10;
    square_y  = 7'd20;
    colour_in = 3'b100;
    start     = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (plot !== 1'b1 || ready !== 1'b0 || done !== 1'b0 ||
          vga_x !== 8'(10 + i % 4) || vga_y !== 7'(20 + i / 4) || vga_colour !== 3'b100) begin
        failures++;
        $display("FAIL single_px%0d got plot=%b rdy=%b done=%b (%0d,%0d) c=%0d want 1 0 0 (%0d,%0d) c=4",
                 i, plot, ready, done, vga_x, vga_y, vga_colour, 10 + i % 4, 20 + i / 4);
      end
      tick;
    end
    checks++;
    if ({done, plot, ready} !== 3'b101) begin
      failures++;
      $display("FAIL single_done got done/plot/ready=%b want 101", {done, plot, ready});
    end
    tick;
    checks++;
    if ({done, plot, ready} !== 3'b001) begin
      failures++;
      $display("FAIL single_idle got done/plot/ready=%b want 001", {done, plot, ready});
    end
  endtask

  task automatic test_back_to_back;
    square_x  = 8'd0;
    square_y  = 7'd30;
    colour_in = 3'b001;
    start     = 1'b1;
    tick;
    square_x  = 8'd5;
    colour_in = 3'b011;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (plot !== 1'b1 || vga_x !== 8'(i % 4) || vga_y !== 7'(30 + i / 4) || vga_colour !== 3'b001) begin
        failures++;
        $display("FAIL b2b_sq1_px%0d got plot=%b (%0d,%0d) c=%0d want 1 (%0d,%0d) c=1",
                 i, plot, vga_x, vga_y, vga_colour, i % 4, 30 + i / 4);
      end
      tick;
    end
    checks++;
    if ({done, plot, ready} !== 3'b101) begin
      failures++;
      $display("FAIL b2b_done1 got done/plot/ready=%b want 101", {done, plot, ready});
    end
    tick;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (plot !== 1'b1 || vga_x !== 8'(5 + i % 4) || vga_y !== 7'(30 + i / 4) || vga_colour !== 3'b011) begin
        failures++;
        $display("FAIL b2b_sq2_px%0d got plot=%b (%0d,%0d) c=%0d want 1 (%0d,%0d) c=3",
                 i, plot, vga_x, vga_y, vga_colour, 5 + i % 4, 30 + i / 4);
      end
      tick;
    end
    checks++;
    if ({done, plot, ready} !== 3'b101) begin
      failures++;
      $display("FAIL b2b_done2 got done/plot/ready=%b want 101", {done, plot, ready});
    end
    tick;
  endtask

  task automatic test_busy_ignore;
    square_x  = 8'd40;
    square_y  = 7'd50;
    colour_in = 3'b010;
    start     = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin
        start     = 1'b1;
        square_x  = 8'd99;
        square_y  = 7'd3;
        colour_in = 3'b101;
      end
      if (i == 6) start = 1'b0;
      checks++;
      if (plot !== 1'b1 || vga_x !== 8'(40 + i % 4) || vga_y !== 7'(50 + i / 4) || vga_colour !== 3'b010) begin
        failures++;
        $display("FAIL busy_px%0d got plot=%b (%0d,%0d) c=%0d want 1 (%0d,%0d) c=2",
                 i, plot, vga_x, vga_y, vga_colour, 40 + i % 4, 50 + i / 4);
      end
      tick;
    end
    checks++;
    if ({done, plot, ready} !== 3'b101) begin
      failures++;
      $display("FAIL busy_done got done/plot/ready=%b want 101", {done, plot, ready});
    end
    tick;
    checks++;
    if (plot !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_no_restart got plot=%b ready=%b want 0 1", plot, ready);
    end
  endtask

  task automatic test_reset_mid;
    square_x  = 8'd60;
    square_y  = 7'd10;
    colour_in = 3'b111;
    start     = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (plot !== 1'b1 || vga_x !== 8'(60 + i % 4) || vga_y !== 7'(10 + i / 4)) begin
        failures++;
        $display("FAIL rmid_px%0d got plot=%b (%0d,%0d) want 1 (%0d,%0d)",
                 i, plot, vga_x, vga_y, 60 + i % 4, 10 + i / 4);
      end
      tick;
    end
    #2;
    clear_b = 1'b0;
    #1;
    checks++;
    if ({plot, done, ready} !== 3'b001 || vga_x !== 8'd0 || vga_y !== 7'd0) begin
      failures++;
      $display("FAIL rmid_async got plot/done/ready=%b x=%0d y=%0d want 001 0 0",
               {plot, done, ready}, vga_x, vga_y);
    end
    tick;
    clear_b = 1'b1;
    tick;
    checks++;
    if (plot !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL rmid_idle got plot=%b ready=%b want 0 1", plot, ready);
    end
    square_x  = 8'd70;
    square_y  = 7'd11;
    colour_in = 3'b101;
    start     = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (plot !== 1'b1 || vga_x !== 8'(70 + i % 4) || vga_y !== 7'(11 + i / 4) || vga_colour !== 3'b101) begin
        failures++;
        $display("FAIL rmid_new_px%0d got plot=%b (%0d,%0d) c=%0d want 1 (%0d,%0d) c=5",
                 i, plot, vga_x, vga_y, vga_colour, 70 + i % 4, 11 + i / 4);
      end
      tick;
    end
    checks++;
    if ({done, plot, ready} !== 3'b101) begin
      failures++;
      $display("FAIL rmid_new_done got done/plot/ready=%b want 101", {done, plot, ready});
    end
    tick;
  endtask

  task automatic test_edge;
    logic [7:0] ex;
    logic [6:0] ey;
    logic       ep;
    int         nplot;
    nplot     = 0;
    square_x  = 8'd158;
    square_y  = 7'd118;
    colour_in = 3'b110;
    start     = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ex = 8'(158 + i % 4);
      ey = 7'(118 + i / 4);
`ifdef DRAW_SQUARE_CLIP_EN
      ep = (ex < 8'd160) && (ey < 7'd120);
`else
      ep = 1'b1;
`endif
      if (plot === 1'b1) nplot++;
      checks++;
      if (plot !== ep || vga_x !== ex || vga_y !== ey || vga_colour !== 3'b110) begin
        failures++;
        $display("FAIL edge_px%0d got plot=%b (%0d,%0d) c=%0d want %b (%0d,%0d) c=6",
                 i, plot, vga_x, vga_y, vga_colour, ep, ex, ey);
      end
      tick;
    end
    checks++;
    if ({done, plot, ready} !== 3'b101) begin
      failures++;
      $display("FAIL edge_done got done/plot/ready=%b want 101", {done, plot, ready});
    end
    checks++;
`ifdef DRAW_SQUARE_CLIP_EN
    if (nplot != 4) begin
      failures++;
      $display("FAIL edge_count got %0d plots want 4", nplot);
    end
`else
    if (nplot != 16) begin
      failures++;
      $display("FAIL edge_count got %0d plots want 16", nplot);
    end
`endif
    tick;
  endtask

  initial begin
    clear_b   = 1'b0;
    start     = 1'b0;
    square_x  = '0;
    square_y  = '0;
    colour_in = '0;
    test_reset;
    test_single;
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid;
    test_edge;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
